i2c_cfg_ctrl: RTL and testbench

- Write-only I2C target that configures the FIR filter coefficient/control register bank from an external I2C controller.
- Oversamples SCL/SDA on the system clock, decodes START/STOP, matches the device address, loads a register pointer, then writes data bytes into the register bank with pointer auto-increment.
- Signals a commit at STOP so the FIR datapath can atomically adopt the new configuration.

---
 rtl/fir_cfg_pkg.sv | 19 +
 rtl/i2c_line_sync.sv | 33 +++
 rtl/i2c_cfg_ctrl.sv | 126 ++++++++++++
 tb/tb_i2c_cfg_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_cfg_pkg.sv
// fir_cfg_pkg: shared types and constants for the FIR configuration I2C target
// and the register bank it writes.
package fir_cfg_pkg;
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        REG,
        ACK_REG,
        DATA,
        ACK_DATA,
        IGNORE
    } i2c_cfg_state_t;

    localparam logic [6:0] I2C_ADDR_DEFAULT = 7'h42;
    localparam int         N_CFG_REGS       = 32;
    localparam int         CFG_COEF_BASE    = 0;
    localparam int         CFG_CTRL_REG     = N_CFG_REGS - 1;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: two-flop synchronizers on SCL/SDA plus a delayed copy of each,
// giving SCL edges and START/STOP conditions in the clk domain.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    // idle bus level is high, so reset to 1 to avoid phantom edges
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_in, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_in, r_sda_s1, r_sda_s2};
        end
    end

    assign scl_rise  = r_scl_s2 & ~r_scl_d;
    assign scl_fall  = ~r_scl_s2 & r_scl_d;
    assign start_det = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign stop_det  = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign sda_s     = r_sda_s2;
endmodule

// File: rtl/i2c_cfg_ctrl.sv
// i2c_cfg_ctrl: write-only I2C target loading a register pointer and data bytes
// into the FIR config bank, with a commit pulse at STOP.
module i2c_cfg_ctrl
    import fir_cfg_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = I2C_ADDR_DEFAULT,
    parameter int         N_REGS   = N_CFG_REGS,
    localparam int        ADDR_W   = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              cfg_we,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [7:0]        cfg_data,
    output logic              cfg_commit,
    output logic              busy
);
    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
    logic w_addr_ok, w_reg_ok;

    i2c_cfg_state_t    r_state;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit_cnt;
    logic              r_byte_done;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_written;
    logic              r_sda_oe, r_we, r_commit, r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop),
        .sda_s     (w_sda)
    );

    assign w_addr_ok = (r_shift[7:1] == I2C_ADDR) && !r_shift[0];
    assign w_reg_ok  = {1'b0, r_shift} < 9'(N_REGS);

    // bytes are judged on the SCL fall after bit 8 so SDA only moves while SCL is low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
            r_ptr       <= '0;
            r_written   <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_we        <= 1'b0;
            r_commit    <= 1'b0;
            r_busy      <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
        end else begin
            r_we     <= 1'b0;
            r_commit <= 1'b0;
            if (w_start) begin
                r_state     <= ADDR;
                r_busy      <= 1'b1;
                r_sda_oe    <= 1'b0;
                r_bit_cnt   <= '0;
                r_byte_done <= 1'b0;
            end else if (w_stop && r_state != IDLE) begin
                r_state     <= IDLE;
                r_busy      <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_commit    <= r_written;
                r_written   <= 1'b0;
                r_bit_cnt   <= '0;
                r_byte_done <= 1'b0;
            end else begin
                case (r_state)
                    ADDR, REG, DATA: begin
                        if (w_scl_rise && !r_byte_done) begin
                            r_shift     <= {r_shift[6:0], w_sda};
                            r_bit_cnt   <= r_bit_cnt + 3'd1;
                            r_byte_done <= (r_bit_cnt == 3'd7);
                        end else if (w_scl_fall && r_byte_done) begin
                            r_byte_done <= 1'b0;
                            if (r_state == ADDR) begin
                                r_state  <= w_addr_ok ? ACK_ADDR : IGNORE;
                                r_sda_oe <= w_addr_ok;
                            end else if (r_state == REG) begin
                                r_state  <= w_reg_ok ? ACK_REG : IGNORE;
                                r_sda_oe <= w_reg_ok;
                                if (w_reg_ok) r_ptr <= r_shift[ADDR_W-1:0];
                            end else begin
                                r_state   <= ACK_DATA;
                                r_sda_oe  <= 1'b1;
                                r_we      <= 1'b1;
                                r_addr    <= r_ptr;
                                r_data    <= r_shift;
                                r_ptr     <= r_ptr + ADDR_W'(1);
                                r_written <= 1'b1;
                            end
                        end
                    end
                    ACK_ADDR, ACK_REG, ACK_DATA: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= (r_state == ACK_ADDR) ? REG : DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe     = r_sda_oe;
    assign cfg_we     = r_we;
    assign cfg_addr   = r_addr;
    assign cfg_data   = r_data;
    assign cfg_commit = r_commit;
    assign busy       = r_busy;
endmodule

// File: tb/tb_i2c_cfg_ctrl.sv
// tb_i2c_cfg_ctrl: directed I2C controller frames; expected register writes and
// commits go into queues that a clk-driven monitor pops and compares.
`timescale 1ns/1ps
module tb_i2c_cfg_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_oe, cfg_we, cfg_commit, busy;
    logic [4:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       sda_line;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [12:0] we_q[$];
    logic        commit_q[$];

    assign sda_line = m_sda & ~sda_oe;

    i2c_cfg_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_in     (scl),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cfg_we) begin
            n_checks++;
            if (we_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_we: got addr=%0d data=%02h expected no write", cfg_addr, cfg_data);
            end else begin
                logic [12:0] e;
                e = we_q.pop_front();
                if ({cfg_addr, cfg_data} !== e) begin
                    n_errors++;
                    $display("FAIL cfg_write: got addr=%0d data=%02h expected addr=%0d data=%02h",
                             cfg_addr, cfg_data, e[12:8], e[7:0]);
                end
            end
        end
        if (rst_n && cfg_commit) begin
            n_checks++;
            if (commit_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_commit: got commit=1 expected none");
            end else begin
                void'(commit_q.pop_front());
            end
        end
    end

    task automatic i2c_start();
        m_sda = 1'b1; scl = 1'b1; #250;
        m_sda = 1'b0; #250;
        scl = 1'b0; #250;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #250;
        scl = 1'b1; #250;
        m_sda = 1'b1; #250;
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; #250;
        scl = 1'b1; #500;
        scl = 1'b0; #250;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; #250;
        scl = 1'b1; #250;
        ack = sda_line; #250;
        scl = 1'b0; #250;
    endtask

    task automatic byte_ack(input string name, input logic [7:0] b, input logic exp);
        logic a;
        send_byte(b, a);
        chk(name, int'(a), int'(exp));
    endtask

    task automatic frame_end(input string name);
        i2c_stop();
        #200;
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_we_left"}, we_q.size(), 0);
        chk({name, "_commit_left"}, commit_q.size(), 0);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_sda_oe", int'(sda_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_we", int'(cfg_we), 0);
        chk("rst_commit", int'(cfg_commit), 0);
        chk("rst_addr", int'(cfg_addr), 0);
        chk("rst_data", int'(cfg_data), 0);
        rst_n = 1'b1;
        #1000;

        // basic write
        we_q.push_back({5'd5, 8'hA5});
        commit_q.push_back(1'b1);
        i2c_start();
        chk("t1_busy", int'(busy), 1);
        byte_ack("t1_ack_addr", 8'h84, 1'b0);
        byte_ack("t1_ack_ptr", 8'h05, 1'b0);
        byte_ack("t1_ack_data", 8'hA5, 1'b0);
        frame_end("t1");

        // wrong address
        i2c_start();
        byte_ack("t2_nack_addr", 8'h86, 1'b1);
        byte_ack("t2_nack_ptr", 8'h05, 1'b1);
        frame_end("t2");

        // pointer wrap
        we_q.push_back({5'd31, 8'h11});
        we_q.push_back({5'd0, 8'h22});
        commit_q.push_back(1'b1);
        i2c_start();
        byte_ack("t3_ack_addr", 8'h84, 1'b0);
        byte_ack("t3_ack_ptr", 8'h1F, 1'b0);
        byte_ack("t3_ack_d0", 8'h11, 1'b0);
        byte_ack("t3_ack_d1", 8'h22, 1'b0);
        frame_end("t3");

        // out of range pointer
        i2c_start();
        byte_ack("t4_ack_addr", 8'h84, 1'b0);
        byte_ack("t4_nack_ptr", 8'h20, 1'b1);
        byte_ack("t4_nack_data", 8'h33, 1'b1);
        frame_end("t4");

        // abort mid-byte, then a good frame
        i2c_start();
        byte_ack("t5_ack_addr", 8'h84, 1'b0);
        byte_ack("t5_ack_ptr", 8'h03, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        frame_end("t5_abort");
        we_q.push_back({5'd3, 8'h5A});
        commit_q.push_back(1'b1);
        i2c_start();
        byte_ack("t5_ack_addr2", 8'h84, 1'b0);
        byte_ack("t5_ack_ptr2", 8'h03, 1'b0);
        byte_ack("t5_ack_data2", 8'h5A, 1'b0);
        frame_end("t5");

        // reset during address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 2);
        m_sda = 1'b1;
        for (int i = 0; i < 100 && !sda_oe; i++) @(negedge clk);
        chk("t6_oe_before_rst", int'(sda_oe), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_oe_after_rst", int'(sda_oe), 0);
        chk("t6_busy_after_rst", int'(busy), 0);
        rst_n = 1'b1;
        #200;
        scl = 1'b1; #500;
        scl = 1'b0; #250;
        i2c_stop();
        we_q.push_back({5'd7, 8'hC3});
        commit_q.push_back(1'b1);
        i2c_start();
        byte_ack("t6_ack_addr", 8'h84, 1'b0);
        byte_ack("t6_ack_ptr", 8'h07, 1'b0);
        byte_ack("t6_ack_data", 8'hC3, 1'b0);
        frame_end("t6");

        repeat (20) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
